// File: rtl/pixel_bit_shifter_pkg.sv
// rtl/pixel_bit_shifter_pkg.sv - shared widths, defaults and FSM encoding for the pixel bit shifter
package pixel_bit_shifter_pkg;

  localparam int GRB_WIDTH        = 24;
  localparam int DEF_LED_COUNT    = 64;
  localparam int DEF_RESET_CYCLES = 3000;

  typedef enum logic [1:0] {
    ST_STREAM    = 2'd0,
    ST_LATCH_ARM = 2'd1,
    ST_LATCH_CNT = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_bit_shifter_if.sv
// rtl/pixel_bit_shifter_if.sv - bit request, status and frame-buffer read signals of the shifter
interface pixel_bit_shifter_if
  import pixel_bit_shifter_pkg::*;
#(
  parameter int LED_COUNT    = DEF_LED_COUNT,
  parameter int BITS_PER_LED = GRB_WIDTH
) ();

  localparam int AW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;

  logic                    new_bit_rqst;
  logic                    bit_to_transmit;
  logic                    all_bits_shifted;
  logic                    reset_finish;
  logic                    frame_sync;
  logic                    pix_rd;
  logic [AW-1:0]           pix_addr;
  logic [BITS_PER_LED-1:0] pix_data;

  // master: the shifter itself (it drives the frame-buffer read port)
  modport master (
    input  new_bit_rqst, pix_data,
    output bit_to_transmit, all_bits_shifted, reset_finish, frame_sync, pix_rd, pix_addr
  );

  modport slave (
    output new_bit_rqst, pix_data,
    input  bit_to_transmit, all_bits_shifted, reset_finish, frame_sync, pix_rd, pix_addr
  );

endinterface

// File: rtl/pixel_bit_shifter_latch_gap_timer.sv
// rtl/pixel_bit_shifter_latch_gap_timer.sv - latch gap counter with terminal-count flag
module pixel_bit_shifter_latch_gap_timer
  import pixel_bit_shifter_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  localparam int GW = $clog2(RESET_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [GW-1:0] o_cnt,
  output logic          o_tc
);

  logic [GW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Not gated by i_en: the caller qualifies it with its own state.
  assign o_tc  = (r_cnt == GW'(RESET_CYCLES - 1));
  assign o_cnt = r_cnt;

endmodule

// File: rtl/pixel_bit_shifter.sv
// rtl/pixel_bit_shifter.sv - prefetching MSB-first pixel serialiser with frame latch gap
module pixel_bit_shifter
  import pixel_bit_shifter_pkg::*;
#(
  parameter int LED_COUNT    = DEF_LED_COUNT,
  parameter int BITS_PER_LED = GRB_WIDTH,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
  input logic                  clk,
  input logic                  rst,
  pixel_bit_shifter_if.master  bus
);

  localparam int AW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam int BW = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam int GW = $clog2(RESET_CYCLES + 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [BITS_PER_LED-1:0] r_shift_reg;
  logic [BITS_PER_LED-1:0] r_next_word;
  logic                    r_next_valid;
  logic                    r_cap;
  logic                    r_all_bits_shifted;
  logic                    r_pix_rd;
  logic [AW-1:0]           r_pix_addr;
  logic [AW-1:0]           r_led_cnt;
  logic [BW-1:0]           r_bit_cnt;

  logic [GW-1:0]           w_gap_cnt;
  logic                    w_gap_en;
  logic                    w_gap_clr;
  logic                    w_gap_tc;
  logic                    w_start;
  logic                    w_shift;
  logic                    w_load_word;
  logic                    w_frame_done;
  logic                    w_last_bit;
  logic                    w_last_led;
  logic                    w_pix_first;
  logic                    w_underrun;

  pixel_bit_shifter_latch_gap_timer #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_gap_clr),
    .i_en  (w_gap_en),
    .o_cnt (w_gap_cnt),
    .o_tc  (w_gap_tc)
  );

  assign w_gap_en    = (r_state == ST_LATCH_CNT);
  assign w_last_bit  = (r_bit_cnt == BW'(BITS_PER_LED - 1));
  assign w_last_led  = (r_led_cnt == AW'(LED_COUNT - 1));
  assign w_pix_first = (r_state == ST_LATCH_CNT) && (w_gap_cnt == '0);
  assign w_underrun  = w_load_word && !r_next_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LATCH_CNT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_gap_clr    = 1'b0;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_load_word  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_LATCH_CNT: begin
        if (w_gap_tc) begin
          w_start      = 1'b1;
          w_next_state = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (bus.new_bit_rqst) begin
          if (!w_last_bit) begin
            w_shift = 1'b1;
          end else if (!w_last_led) begin
            w_load_word = 1'b1;
          end else begin
            w_frame_done = 1'b1;
            w_next_state = ST_LATCH_ARM;
          end
        end
      end
      ST_LATCH_ARM: begin
        // This request closes the last bit period; the gap starts now.
        if (bus.new_bit_rqst) begin
          w_gap_clr    = 1'b1;
          w_next_state = ST_LATCH_CNT;
        end
      end
      default: w_next_state = ST_LATCH_CNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift_reg        <= '0;
      r_next_word        <= '0;
      r_next_valid       <= 1'b0;
      r_cap              <= 1'b0;
      r_all_bits_shifted <= 1'b1;
      r_pix_rd           <= 1'b0;
      r_pix_addr         <= '0;
      r_led_cnt          <= '0;
      r_bit_cnt          <= '0;
    end else begin
      r_pix_rd <= 1'b0;
      r_cap    <= r_pix_rd;
      if (w_pix_first) begin
        r_pix_rd   <= 1'b1;
        r_pix_addr <= '0;
      end
      if (w_start) begin
        r_shift_reg        <= r_next_word;
        r_next_valid       <= 1'b0;
        r_all_bits_shifted <= 1'b0;
        r_bit_cnt          <= '0;
        r_led_cnt          <= '0;
        r_pix_rd           <= 1'b1;
        r_pix_addr         <= AW'(1);
      end
      if (w_shift) begin
        r_shift_reg <= r_shift_reg << 1;
        r_bit_cnt   <= r_bit_cnt + 1'b1;
      end
      if (w_load_word) begin
        // An empty prefetch slot is a fault; send a dark pixel and keep going.
        r_shift_reg  <= r_next_valid ? r_next_word : '0;
        r_next_valid <= 1'b0;
        r_bit_cnt    <= '0;
        r_led_cnt    <= r_led_cnt + 1'b1;
        if (r_led_cnt != AW'(LED_COUNT - 2)) begin
          r_pix_rd   <= 1'b1;
          r_pix_addr <= r_led_cnt + AW'(2);
        end
      end
      if (w_frame_done) begin
        r_all_bits_shifted <= 1'b1;
      end
      if (r_cap) begin
        r_next_word  <= bus.pix_data;
        r_next_valid <= 1'b1;
      end
    end
  end

  assign bus.bit_to_transmit  = (r_state == ST_STREAM) && r_shift_reg[BITS_PER_LED-1];
  assign bus.all_bits_shifted = r_all_bits_shifted;
  assign bus.reset_finish     = w_start;
  assign bus.frame_sync       = w_start;
  assign bus.pix_rd           = r_pix_rd;
  assign bus.pix_addr         = r_pix_addr;

endmodule

// File: tb/tb_pixel_bit_shifter.sv
// tb/tb_pixel_bit_shifter.sv - scoreboard bench for pixel_bit_shifter with a frame-level reference model
module tb_pixel_bit_shifter;

  localparam int LEDS = 3;
  localparam int BPL  = 24;
  localparam int RC   = 100;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_req = 0;
  int   rel = 0;

  logic [BPL-1:0] mem [LEDS];
  bit             q_bits [$];
  int             q_addr [$];
  int             q_rf   [$];

  pixel_bit_shifter_if #(.LED_COUNT(LEDS), .BITS_PER_LED(BPL)) bus ();

  pixel_bit_shifter #(
    .LED_COUNT    (LEDS),
    .BITS_PER_LED (BPL),
    .RESET_CYCLES (RC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous frame buffer, one cycle read latency
  always @(posedge clk) if (bus.pix_rd) bus.pix_data <= mem[bus.pix_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a frame is every LED word in address order, MSB first
  task automatic push_frame();
    for (int led = 0; led < LEDS; led++) begin
      for (int b = BPL - 1; b >= 0; b--) q_bits.push_back(mem[led][b]);
      q_addr.push_back(led);
    end
  endtask

  task automatic send_bit(input int gap);
    repeat (gap - 1) begin @(posedge clk); #1; end
    bus.new_bit_rqst = 1'b1;
    last_req = cyc;
    @(posedge clk); #1;
    bus.new_bit_rqst = 1'b0;
  endtask

  task automatic run_bits(input int n, input bit slow);
    for (int i = 0; i < n; i++) begin
      if (i == 0) send_bit(1);
      else if (slow && i < BPL) send_bit(60);
      else send_bit(int'($urandom_range(1, 4)));
    end
  endtask

  // Runs up to the expected reset_finish cycle, optionally with ignored requests
  task automatic gap_to(input int target, input bit noise);
    while (cyc < target) begin
      bus.new_bit_rqst = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(posedge clk); #1;
    end
    bus.new_bit_rqst = noise;
    @(posedge clk); #1;
    bus.new_bit_rqst = 1'b0;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < LEDS; i++) mem[i] = BPL'($urandom);
  endtask

  task automatic end_frame_checks(input string tag);
    chk({tag, "_abs_high"}, 32'(bus.all_bits_shifted), 1);
    chk({tag, "_bits_left"}, q_bits.size(), 0);
    chk({tag, "_addr_left"}, q_addr.size(), 0);
  endtask

  task automatic next_frame();
    randomize_mem();
    push_frame();
    send_bit(3);
    q_rf.push_back(last_req + RC);
    gap_to(last_req + RC, 1'b1);
    chk("abs_fall", 32'(bus.all_bits_shifted), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.new_bit_rqst && !bus.all_bits_shifted) begin
        chk("underrun", 32'(dut.w_underrun), 0);
        if (q_bits.size() == 0) chk("extra_bit", 1, 0);
        else chk("bit", 32'(bus.bit_to_transmit), 32'(q_bits.pop_front()));
      end
      if (bus.pix_rd) begin
        if (q_addr.size() == 0) chk("extra_pix_rd", 1, 0);
        else chk("pix_addr", 32'(bus.pix_addr), q_addr.pop_front());
      end
      if (bus.reset_finish) begin
        chk("rf_abs", 32'(bus.all_bits_shifted), 1);
        if (q_rf.size() == 0) chk("extra_reset_finish", 1, 0);
        else chk("rf_cycle", cyc, q_rf.pop_front());
      end
      if (bus.frame_sync !== bus.reset_finish)
        chk("frame_sync", 32'(bus.frame_sync), 32'(bus.reset_finish));
    end
  end

  initial begin
    rst = 1'b1;
    bus.new_bit_rqst = 1'b0;
    randomize_mem();
    mem[0] = 24'hA50FC3;
    push_frame();
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_bit", 32'(bus.bit_to_transmit), 0);
    chk("rst_abs", 32'(bus.all_bits_shifted), 1);
    chk("rst_rf", 32'(bus.reset_finish), 0);
    chk("rst_fs", 32'(bus.frame_sync), 0);
    chk("rst_pix_rd", 32'(bus.pix_rd), 0);
    chk("rst_pix_addr", 32'(bus.pix_addr), 0);

    // Frame 1: startup gap, slow first word, then fast bits
    rst = 1'b0;
    rel = cyc;
    q_rf.push_back(rel + RC - 1);
    #3 chk("cyc0_pix_rd", 32'(bus.pix_rd), 0);
    @(posedge clk); #1;
    chk("cyc1_pix_rd", 32'(bus.pix_rd), 1);
    chk("cyc1_pix_addr", 32'(bus.pix_addr), 0);
    gap_to(rel + RC - 1, 1'b0);
    chk("abs_fall", 32'(bus.all_bits_shifted), 0);
    run_bits(LEDS * BPL, 1'b1);
    end_frame_checks("f1");

    // Frame 2: rewritten buffer, noisy gap, request on reset_finish
    next_frame();
    run_bits(LEDS * BPL, 1'b0);
    end_frame_checks("f2");

    // Frame 3: aborted by reset at LED 1 bit 10
    next_frame();
    run_bits(BPL + 10, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("abort_bit", 32'(bus.bit_to_transmit), 0);
    chk("abort_abs", 32'(bus.all_bits_shifted), 1);
    chk("abort_rf", 32'(bus.reset_finish), 0);
    chk("abort_pix_rd", 32'(bus.pix_rd), 0);
    chk("abort_pix_addr", 32'(bus.pix_addr), 0);
    q_bits.delete();
    q_addr.delete();
    q_rf.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Frame 4: full startup gap after the abort, then a complete frame
    randomize_mem();
    push_frame();
    rst = 1'b0;
    rel = cyc;
    q_rf.push_back(rel + RC - 1);
    gap_to(rel + RC - 1, 1'b1);
    chk("abs_fall", 32'(bus.all_bits_shifted), 0);
    run_bits(LEDS * BPL, 1'b0);
    end_frame_checks("f4");
    chk("rf_left", q_rf.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_bit_shifter.md
Name: pixel_bit_shifter

Overview:
- Upstream feeder of the LED-stripe bit timing stage. Fetches 24-bit GRB pixels from the frame buffer (synchronous RAM, 1-cycle read latency) and serialises them MSB first.
- Presents one bit per new_bit_rqst pulse.
- After the last bit of the last LED, flags all_bits_shifted, times the latch/reset gap and pulses reset_finish so the timing stage restarts the frame.

Parameters:
- LED_COUNT, 64, number of LEDs on the stripe (>=2)
- BITS_PER_LED, 24, bits per pixel word
- RESET_CYCLES, 3000, latch gap in clk cycles (60 us at 50 MHz)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- new_bit_rqst  in  1  single-cycle request; current bit is consumed this cycle
- bit_to_transmit  out  1  bit valid whenever a request can arrive
- all_bits_shifted  out  1  high from last-bit consumption until reset_finish
- reset_finish  out  1  single-cycle pulse, end of latch gap
- frame_sync  out  1  single-cycle pulse coincident with reset_finish; frame buffer may be rewritten until first pix_rd of next frame
- pix_rd  out  1  frame-buffer read strobe
- pix_addr  out  clog2(LED_COUNT)  LED index to read
- pix_data  in  BITS_PER_LED  read data, valid cycle after pix_rd

Behaviour:
- Registers:
  - shift_reg (current word)
  - next_word plus next_valid (prefetch)
  - bit_cnt 0..BITS_PER_LED-1
  - led_cnt 0..LED_COUNT-1
  - gap_cnt, clog2(RESET_CYCLES+1) bits
- bit_to_transmit = shift_reg MSB, combinational from register; forced 0 outside STREAM.
- Output reset values:
  - bit_to_transmit=0, all_bits_shifted=1, reset_finish=0, frame_sync=0, pix_rd=0, pix_addr=0.
- Reset state:
  - State LATCH_CNT, gap_cnt=0, led_cnt=0, bit_cnt=0, next_valid=0.
  - The startup gap is a full latch.
- FSM states STREAM, LATCH_ARM, LATCH_CNT:
  - LATCH_CNT:
    - gap_cnt increments every cycle.
    - On the first cycle in the state, pix_rd=1, pix_addr=0 (prefetch pixel 0); the cycle after, next_word<=pix_data, next_valid<=1.
    - When gap_cnt==RESET_CYCLES-1: reset_finish=1, frame_sync=1, shift_reg<=next_word, next_valid<=0, all_bits_shifted<=0, bit_cnt<=0, led_cnt<=0, go STREAM.
    - Requests in LATCH_CNT are ignored.
  - STREAM:
    - On the first STREAM cycle, and on every word load, issue pix_rd for led_cnt+1 if led_cnt<LED_COUNT-1; capture next cycle.
    - On new_bit_rqst:
      - if bit_cnt<BITS_PER_LED-1: shift left, bit_cnt++.
      - else if led_cnt<LED_COUNT-1: shift_reg<=next_word, next_valid<=0, bit_cnt<=0, led_cnt++.
      - else (last bit of last LED): all_bits_shifted<=1, go LATCH_ARM.
  - LATCH_ARM:
    - Waits for the next new_bit_rqst, which marks the end of the last bit period.
    - On it: gap_cnt<=0, go LATCH_CNT (prefetch of pixel 0 starts next cycle).
- Latency:
  - The request-to-next-bit change is 1 cycle.
  - The first request after reset_finish arrives 1 cycle later, and shift_reg is already loaded.
- Underrun:
  - A word-boundary request with next_valid=0 cannot occur if the bit period is >=3 cycles.
  - It is treated as a fault: load 0 and continue.
  - The bench asserts it never occurs.
- Boundaries:
  - LED_COUNT-1 wrap returns to address 0.
  - A request coincident with reset_finish is ignored.
  - rst mid-frame aborts immediately to LATCH_CNT with all counters cleared.
  - Back-to-back requests in consecutive cycles are legal in STREAM.

Decomposition:
- Shared package holds GRB word width, default LED_COUNT and RESET_CYCLES, and the state encoding constants.
- One sub-module is natural: latch_gap_timer (gap_cnt plus terminal-count pulse), reusable by other stripe drivers.

Test Plan:
- Reset release, no requests -> pix_rd with addr 0 at cycle 1; reset_finish and frame_sync single pulse at cycle RESET_CYCLES-1; all_bits_shifted falls same edge.
- pix_data[0]=24'hA5_0F_C3, 24 requests every 60 cycles -> bit_to_transmit sequence 1010_0101_0000_1111_1100_0011, MSB first.
- LED_COUNT=3, distinct words, full frame -> 72 bits in address order; pix_rd addresses 0,1,2 exactly once each; all_bits_shifted rises after bit 72.
- After bit 72, next request -> LATCH_CNT; reset_finish exactly RESET_CYCLES cycles later; extra requests during the gap change nothing.
- Requests on consecutive cycles across a word boundary -> no bit lost, next_word used, no underrun flag.
- rst pulsed at LED 1 bit 10 -> outputs return to reset values asynchronously; next frame restarts at addr 0 after a full gap.
